// File: rtl/vxe_vpu_cmd_dispatch.sv
// VPU command dispatcher: pops the VPU command queue, issues per-thread
// setup writes, broadcasts PROD/STORE runs and serialises on busy/SYNC.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   o_busy          dispatcher not idle (state or pending setup write)
//   i_vld/o_rd      queue handshake; o_rd pops in the same cycle
//   i_op/i_th/i_pl  command opcode, target thread, 48-bit payload
//   o_wr_*          registered one-cycle setup write (RS/RT/RD/LEN)
//   o_run*          one-cycle run strobe; op/arg/mask hold until next run
//   i_th_busy       per-thread busy from the thread units
//   o_sync          one-cycle SYNC completion pulse
//   i_err_clr       clears the sticky bad-opcode flag
//   o_err/o_err_op  sticky bad-opcode flag and first offending opcode
//
// Build option: define VXE_VPU_DISPATCH_ERR_EN to enable the bad-opcode
// flag. Without it unknown opcodes are silently consumed and o_err /
// o_err_op are tied to zero.

module vxe_vpu_cmd_dispatch #(
  parameter int NR_THREADS = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_busy,
  input  logic        i_vld,
  output logic        o_rd,
  input  logic [4:0]  i_op,
  input  logic [2:0]  i_th,
  input  logic [47:0] i_pl,
  output logic        o_wr_vld,
  output logic [2:0]  o_wr_th,
  output logic [1:0]  o_wr_sel,
  output logic [47:0] o_wr_data,
  output logic        o_run,
  output logic        o_run_op,
  output logic [7:0]  o_run_arg,
  output logic [7:0]  o_run_mask,
  input  logic [7:0]  i_th_busy,
  output logic        o_sync,
  input  logic        i_err_clr,
  output logic        o_err,
  output logic [4:0]  o_err_op
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_GUARD = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_SYNC  = 3'd4;

  localparam logic [4:0] OP_NOP    = 5'h00;
  localparam logic [4:0] OP_SETRS  = 5'h08;
  localparam logic [4:0] OP_SETRT  = 5'h09;
  localparam logic [4:0] OP_SETRD  = 5'h0A;
  localparam logic [4:0] OP_SETLEN = 5'h0B;
  localparam logic [4:0] OP_SETEN  = 5'h0C;
  localparam logic [4:0] OP_PROD   = 5'h10;
  localparam logic [4:0] OP_STORE  = 5'h11;
  localparam logic [4:0] OP_SYNC   = 5'h1F;

  // Thread-count helpers: NR_TH for range checks, TH_MASK to ignore
  // busy bits of thread units that do not exist.
  localparam logic [3:0] NR_TH   = 4'(NR_THREADS);
  localparam logic [8:0] TH_ONE  = 9'd1 << NR_THREADS;
  localparam logic [7:0] TH_MASK = 8'(TH_ONE - 9'd1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  mask_q, mask_d;
  logic        wr_vld_q, wr_vld_d;
  logic [2:0]  wr_th_q, wr_th_d;
  logic [1:0]  wr_sel_q, wr_sel_d;
  logic [47:0] wr_data_q, wr_data_d;
  logic        run_op_q, run_op_d;
  logic [7:0]  run_arg_q, run_arg_d;
  logic [7:0]  run_mask_q, run_mask_d;

  logic pop;
  logic th_ok;
  logic th_idle;
  logic run_done;
  logic bad_op;

  // The queue head is consumed on the same edge that o_rd is high.
  assign pop      = (state_q == S_IDLE) & i_vld & ~rst;
  assign th_ok    = {1'b0, i_th} < NR_TH;
  assign th_idle  = (i_th_busy & TH_MASK) == 8'h00;
  assign run_done = (i_th_busy & run_mask_q) == 8'h00;

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    wr_vld_d   = 1'b0;
    wr_th_d    = wr_th_q;
    wr_sel_d   = wr_sel_q;
    wr_data_d  = wr_data_q;
    run_op_d   = run_op_q;
    run_arg_d  = run_arg_q;
    run_mask_d = run_mask_q;
    bad_op     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          unique case (i_op)
            OP_NOP: begin
            end
            OP_SETRS, OP_SETRT, OP_SETRD, OP_SETLEN: begin
              wr_vld_d  = 1'b1;
              wr_th_d   = i_th;
              wr_sel_d  = i_op[1:0];
              wr_data_d = i_pl;
            end
            OP_SETEN: begin
              if (th_ok) begin
                mask_d[i_th] = i_pl[0];
              end
            end
            OP_PROD, OP_STORE: begin
              // A run with no enabled thread is dropped.
              if (mask_q != 8'h00) begin
                state_d    = S_ISSUE;
                run_op_d   = i_op[0];
                run_arg_d  = i_pl[7:0];
                run_mask_d = mask_q;
              end
            end
            OP_SYNC: begin
              state_d = S_SYNC;
            end
            default: begin
              bad_op = 1'b1;
            end
          endcase
        end
      end
      S_ISSUE: begin
        state_d = S_GUARD;
      end
      // Threads raise busy only after seeing o_run, so one cycle is
      // spent here before busy is trusted.
      S_GUARD: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (run_done) begin
          state_d = S_IDLE;
        end
      end
      S_SYNC: begin
        if (th_idle) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mask_q     <= 8'h00;
      wr_vld_q   <= 1'b0;
      wr_th_q    <= 3'd0;
      wr_sel_q   <= 2'd0;
      wr_data_q  <= 48'h0;
      run_op_q   <= 1'b0;
      run_arg_q  <= 8'h00;
      run_mask_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      wr_vld_q   <= wr_vld_d;
      wr_th_q    <= wr_th_d;
      wr_sel_q   <= wr_sel_d;
      wr_data_q  <= wr_data_d;
      run_op_q   <= run_op_d;
      run_arg_q  <= run_arg_d;
      run_mask_q <= run_mask_d;
    end
  end

  assign o_rd       = pop;
  assign o_busy     = (state_q != S_IDLE) | wr_vld_q;
  assign o_wr_vld   = wr_vld_q;
  assign o_wr_th    = wr_th_q;
  assign o_wr_sel   = wr_sel_q;
  assign o_wr_data  = wr_data_q;
  // Strobes are masked by rst so an aborted operation never pulses.
  assign o_run      = (state_q == S_ISSUE) & ~rst;
  assign o_run_op   = run_op_q;
  assign o_run_arg  = run_arg_q;
  assign o_run_mask = run_mask_q;
  assign o_sync     = (state_q == S_SYNC) & th_idle & ~rst;

`ifdef VXE_VPU_DISPATCH_ERR_EN
  logic       err_q, err_d;
  logic [4:0] err_op_q, err_op_d;

  // Clear wins over a coinciding new error; only the first bad
  // opcode after a clear is recorded.
  always_comb begin
    err_d    = err_q;
    err_op_d = err_op_q;
    if (i_err_clr) begin
      err_d = 1'b0;
    end else if (bad_op && !err_q) begin
      err_d    = 1'b1;
      err_op_d = i_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q    <= 1'b0;
      err_op_q <= 5'h00;
    end else begin
      err_q    <= err_d;
      err_op_q <= err_op_d;
    end
  end

  assign o_err    = err_q;
  assign o_err_op = err_op_q;
`else
  logic unused_err;
  assign unused_err = i_err_clr ^ bad_op;
  assign o_err      = 1'b0;
  assign o_err_op   = 5'h00;
`endif

endmodule

// File: tb/tb_vxe_vpu_cmd_dispatch.sv
// Self-checking bench for vxe_vpu_cmd_dispatch: transaction-level model
// plus directed scenarios with literal expectations.

module tb_vxe_vpu_cmd_dispatch;

  localparam int NR = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        o_busy;
  logic        i_vld = 1'b0;
  logic        o_rd;
  logic [4:0]  i_op = 5'h0;
  logic [2:0]  i_th = 3'h0;
  logic [47:0] i_pl = 48'h0;
  logic        o_wr_vld;
  logic [2:0]  o_wr_th;
  logic [1:0]  o_wr_sel;
  logic [47:0] o_wr_data;
  logic        o_run;
  logic        o_run_op;
  logic [7:0]  o_run_arg;
  logic [7:0]  o_run_mask;
  logic [7:0]  i_th_busy = 8'h0;
  logic        o_sync;
  logic        i_err_clr = 1'b0;
  logic        o_err;
  logic [4:0]  o_err_op;

  always #5 clk = ~clk;

  vxe_vpu_cmd_dispatch #(.NR_THREADS(NR)) dut (
    .clk(clk), .rst(rst), .o_busy(o_busy),
    .i_vld(i_vld), .o_rd(o_rd),
    .i_op(i_op), .i_th(i_th), .i_pl(i_pl),
    .o_wr_vld(o_wr_vld), .o_wr_th(o_wr_th),
    .o_wr_sel(o_wr_sel), .o_wr_data(o_wr_data),
    .o_run(o_run), .o_run_op(o_run_op),
    .o_run_arg(o_run_arg), .o_run_mask(o_run_mask),
    .i_th_busy(i_th_busy), .o_sync(o_sync),
    .i_err_clr(i_err_clr), .o_err(o_err), .o_err_op(o_err_op)
  );

  typedef struct packed {
    logic [4:0]  op;
    logic [2:0]  th;
    logic [47:0] pl;
  } cmd_t;

  cmd_t q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic       rst_req = 1'b1;
  logic       clr_req = 1'b0;
  int         busy_cnt = 0;
  logic [7:0] busy_val = 8'h0;
  int         run_len = 0;

  // model state: blk 0 = accepting, 1 = run in flight, 2 = sync
  int          blk = 0;
  int          age = 0;
  logic [7:0]  m_mask = 8'h0;
  logic        e_wr_vld = 1'b0;
  logic [2:0]  e_wr_th = 3'h0;
  logic [1:0]  e_wr_sel = 2'h0;
  logic [47:0] e_wr_data = 48'h0;
  logic        e_run_op = 1'b0;
  logic [7:0]  e_run_arg = 8'h0;
  logic [7:0]  e_run_mask = 8'h0;
  logic        e_err = 1'b0;
  logic [4:0]  e_err_op = 5'h0;

  // observations for literal checks
  int          n_run = 0, n_sync = 0, n_wr = 0;
  int          t_run = 0, t_sync = 0;
  int          last_pop = 0, prev_pop = 0;
  logic [7:0]  obs_run_mask = 8'h0, obs_run_arg = 8'h0;
  logic        obs_run_op = 1'b0;
  logic [2:0]  obs_wr_th = 3'h0;
  logic [1:0]  obs_wr_sel = 2'h0;
  logic [47:0] obs_wr_data = 48'h0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [4:0] op, input logic [2:0] th,
                      input logic [47:0] pl);
    cmd_t c;
    c.op = op;
    c.th = th;
    c.pl = pl;
    q.push_back(c);
  endtask

  function automatic bit is_known(input logic [4:0] op);
    return op == 5'h00 || (op >= 5'h08 && op <= 5'h0C) ||
           op == 5'h10 || op == 5'h11 || op == 5'h1F;
  endfunction

  task automatic cycle();
    cmd_t c;
    logic vld, e_rd, e_run, e_sync, e_busy, bad, nxt_wr;
    @(negedge clk);
    cyc++;
    rst = rst_req;
    i_err_clr = clr_req;
    vld = q.size() > 0;
    i_vld = vld;
    c = '0;
    if (vld) begin
      c = q[0];
      i_op = c.op;
      i_th = c.th;
      i_pl = c.pl;
    end else begin
      i_op = 5'($urandom);
      i_th = 3'($urandom);
      i_pl = 48'({$urandom, $urandom});
    end
    i_th_busy = (busy_cnt > 0) ? busy_val : 8'h0;
    if (busy_cnt > 0) busy_cnt--;
    #1;
    if (rst) begin
      blk = 0; age = 0; m_mask = '0; e_wr_vld = 0;
      e_wr_th = '0; e_wr_sel = '0; e_wr_data = '0;
      e_run_op = 0; e_run_arg = '0; e_run_mask = '0;
      e_err = 0; e_err_op = '0;
    end else begin
      e_rd   = (blk == 0) && vld;
      e_run  = (blk == 1) && (age == 1);
      e_sync = (blk == 2) && (i_th_busy == 8'h0);
      e_busy = (blk != 0) || e_wr_vld;
      chk("rd", o_rd, e_rd);
      chk("run", o_run, e_run);
      chk("sync", o_sync, e_sync);
      chk("busy", o_busy, e_busy);
      chk("wr_vld", o_wr_vld, e_wr_vld);
      if (e_wr_vld) begin
        chk("wr_th", o_wr_th, e_wr_th);
        chk("wr_sel", o_wr_sel, e_wr_sel);
        chk("wr_data", o_wr_data, e_wr_data);
      end
      chk("run_op", o_run_op, e_run_op);
      chk("run_arg", o_run_arg, e_run_arg);
      chk("run_mask", o_run_mask, e_run_mask);
      chk("err", o_err, e_err);
      chk("err_op", o_err_op, e_err_op);

      if (o_run) begin
        n_run++; t_run = cyc;
        obs_run_mask = o_run_mask;
        obs_run_arg = o_run_arg;
        obs_run_op = o_run_op;
      end
      if (o_sync) begin
        n_sync++; t_sync = cyc;
      end
      if (o_wr_vld) begin
        n_wr++;
        obs_wr_th = o_wr_th;
        obs_wr_sel = o_wr_sel;
        obs_wr_data = o_wr_data;
      end
      if (o_rd && vld) begin
        prev_pop = last_pop;
        last_pop = cyc;
      end

      nxt_wr = 1'b0;
      bad = 1'b0;
      if (blk == 0 && vld) begin
        if (c.op >= 5'h08 && c.op <= 5'h0B) begin
          nxt_wr = 1'b1;
          e_wr_th = c.th;
          e_wr_sel = 2'(c.op - 5'h08);
          e_wr_data = c.pl;
        end else if (c.op == 5'h0C) begin
          if (int'(c.th) < NR) m_mask[c.th] = c.pl[0];
        end else if (c.op == 5'h10 || c.op == 5'h11) begin
          if (m_mask != 8'h0) begin
            blk = 1; age = 1;
            e_run_op = (c.op == 5'h11);
            e_run_arg = c.pl[7:0];
            e_run_mask = m_mask;
          end
        end else if (c.op == 5'h1F) begin
          blk = 2; age = 1;
        end else if (!is_known(c.op)) begin
          bad = 1'b1;
        end
      end else if (blk == 1) begin
        if (age >= 3 && (i_th_busy & e_run_mask) == 8'h0) blk = 0;
        else age++;
      end else if (blk == 2) begin
        if (e_sync) blk = 0;
      end
`ifdef VXE_VPU_DISPATCH_ERR_EN
      if (clr_req) e_err = 1'b0;
      else if (bad && !e_err) begin
        e_err = 1'b1;
        e_err_op = c.op;
      end
`endif
      e_wr_vld = nxt_wr;
    end
    if (o_rd && vld) void'(q.pop_front());
    if (o_run && run_len > 0) begin
      busy_val = o_run_mask;
      busy_cnt = run_len;
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_rd"}, o_rd, 0);
    chk({tag, "_wr_vld"}, o_wr_vld, 0);
    chk({tag, "_wr_data"}, o_wr_data, 0);
    chk({tag, "_run"}, o_run, 0);
    chk({tag, "_run_arg"}, o_run_arg, 0);
    chk({tag, "_run_mask"}, o_run_mask, 0);
    chk({tag, "_sync"}, o_sync, 0);
    chk({tag, "_err"}, o_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    run(2);
    rst_req = 1'b0;
    cycle();
    chk_all_zero("reset");

    // single setup write, then back-to-back writes
    push(5'h08, 3'd3, 48'h0000_1234_5678);
    run(2);
    chk("setrs_n", n_wr, 1);
    chk("setrs_th", obs_wr_th, 3);
    chk("setrs_sel", obs_wr_sel, 0);
    chk("setrs_data", obs_wr_data, 48'h1234_5678);
    chk("setrs_norun", n_run, 0);
    push(5'h09, 3'd1, 48'hAAAA_0000_0001);
    push(5'h0A, 3'd2, 48'h5555_0000_0002);
    push(5'h0B, 3'd7, 48'h0000_0000_0040);
    run(4);
    chk("b2b_n", n_wr, 4);
    chk("b2b_sel", obs_wr_sel, 3);
    chk("b2b_th", obs_wr_th, 7);

    // PROD to threads 0 and 5, busy for 4 cycles
    run_len = 4;
    push(5'h0C, 3'd0, 48'h1);
    push(5'h0C, 3'd5, 48'h1);
    push(5'h10, 3'd0, 48'h0000_0000_00A5);
    push(5'h00, 3'd0, 48'h0);
    run(14);
    chk("prod_n", n_run, 1);
    chk("prod_mask", obs_run_mask, 8'h21);
    chk("prod_op", obs_run_op, 0);
    chk("prod_arg", obs_run_arg, 8'hA5);
    chk("prod_next_pop", last_pop - t_run, 6);

    // STORE with no busy: minimum turnaround
    run_len = 0;
    push(5'h11, 3'd0, 48'h0000_0000_003C);
    push(5'h00, 3'd0, 48'h0);
    run(8);
    chk("store_n", n_run, 2);
    chk("store_op", obs_run_op, 1);
    chk("store_arg", obs_run_arg, 8'h3C);
    chk("store_next_pop", last_pop - t_run, 3);

    // STORE with an empty mask is dropped
    push(5'h0C, 3'd0, 48'h0);
    push(5'h0C, 3'd5, 48'h0);
    push(5'h11, 3'd0, 48'h0000_0000_0077);
    run(5);
    chk("mask0_n", n_run, 2);
    chk("mask0_busy", o_busy, 0);
    chk("mask0_arg_hold", o_run_arg, 8'h3C);

    // SYNC while thread 1 busy for 6 cycles
    busy_val = 8'h02;
    busy_cnt = 6;
    push(5'h1F, 3'd0, 48'h0);
    push(5'h00, 3'd0, 48'h0);
    run(10);
    chk("sync_busy_n", n_sync, 1);
    chk("sync_busy_lat", t_sync - prev_pop, 6);
    chk("sync_busy_next", last_pop - t_sync, 1);

    // SYNC with everything idle
    push(5'h1F, 3'd0, 48'h0);
    push(5'h00, 3'd0, 48'h0);
    run(4);
    chk("sync_idle_n", n_sync, 2);
    chk("sync_idle_lat", t_sync - prev_pop, 1);
    chk("sync_idle_next", last_pop - t_sync, 1);

    // reset while waiting on a run
    run_len = 10;
    push(5'h0C, 3'd2, 48'h1);
    push(5'h10, 3'd0, 48'h0000_0000_005A);
    run(6);
    chk("wrst_n", n_run, 3);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    busy_cnt = 0;
    cycle();
    chk_all_zero("wrst");
    push(5'h10, 3'd0, 48'h0000_0000_0011);
    run(6);
    chk("wrst_nomask", n_run, 3);
    run_len = 2;
    push(5'h0C, 3'd2, 48'h1);
    push(5'h10, 3'd0, 48'h0000_0000_0022);
    run(10);
    chk("wrst_rerun_n", n_run, 4);
    chk("wrst_rerun_mask", obs_run_mask, 8'h04);
    chk("wrst_rerun_arg", obs_run_arg, 8'h22);

    // unknown opcodes
    push(5'h15, 3'd0, 48'h0);
    run(3);
`ifdef VXE_VPU_DISPATCH_ERR_EN
    chk("bad1_err", o_err, 1);
    chk("bad1_op", o_err_op, 5'h15);
`else
    chk("bad1_err", o_err, 0);
    chk("bad1_op", o_err_op, 5'h00);
`endif
    chk("bad1_busy", o_busy, 0);
    push(5'h16, 3'd0, 48'h0);
    run(3);
`ifdef VXE_VPU_DISPATCH_ERR_EN
    chk("bad2_op", o_err_op, 5'h15);
`else
    chk("bad2_op", o_err_op, 5'h00);
`endif
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    cycle();
    chk("clr_err", o_err, 0);
    push(5'h17, 3'd0, 48'h0);
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    cycle();
    chk("clr_prio_err", o_err, 0);
    push(5'h18, 3'd0, 48'h0);
    run(3);
`ifdef VXE_VPU_DISPATCH_ERR_EN
    chk("bad3_err", o_err, 1);
    chk("bad3_op", o_err_op, 5'h18);
`else
    chk("bad3_err", o_err, 0);
`endif
    chk("bad_norun", n_run, 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
